median_arbiter: RTL and testbench

Round-robin arbiter that shares one MEDIAN 3x3 median filter between NREQ pixel requesters.
- Grants the filter to one requester at a time and muxes that requester's 9-pixel burst onto the filter input.
- Routes the filter's result strobe back to the granted requester only.
- Polices burst length and grant timeouts so a misbehaving requester cannot lock the shared filter.

---
 rtl/median_pkg.sv | 9 +
 rtl/rr_pick.sv | 33 +++
 rtl/median_arbiter.sv | 139 +++++++++++++
 tb/tb_median_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/median_pkg.sv
// Shared state encoding and burst constants for the median filter arbiter.
package median_pkg;

    typedef enum logic [2:0] {IDLE, GRANT, LOAD, WAIT, GAP} state_t;

    localparam int BURST_LEN   = 9;
    localparam int MED_LATENCY = 41;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr_i, wrapping.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [NREQ-1:0] onehot_o,
    output logic [IW-1:0]   idx_o,
    output logic            valid_o
);

    logic [IW-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest hit is the one that sticks.
    always_comb begin
        idx_o    = '0;
        valid_o  = 1'b0;
        cand     = '0;
        onehot_o = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = IW'((int'(ptr_i) + k) % NREQ);
            if (req_i[cand]) begin
                idx_o   = cand;
                valid_o = 1'b1;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            onehot_o[i] = valid_o && (idx_o == IW'(i));
        end
    end

endmodule

// File: rtl/median_arbiter.sv
// Round-robin arbiter sharing one 3x3 median filter between NREQ pixel requesters,
// with burst-length and grant-timeout policing.
module median_arbiter
    import median_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int WIDTH  = 8,
    parameter int GNT_TO = 16
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic [NREQ-1:0]       REQ,
    output logic [NREQ-1:0]       GNT,
    input  logic [NREQ-1:0]       DSI_REQ,
    input  logic [NREQ*WIDTH-1:0] DI_REQ,
    output logic [NREQ-1:0]       DSO_REQ,
    output logic [WIDTH-1:0]      DO,
    output logic                  M_DSI,
    output logic [WIDTH-1:0]      M_DI,
    input  logic [WIDTH-1:0]      M_DO,
    input  logic                  M_DSO,
    output logic                  BUSY,
    output logic                  ERR
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = $clog2(GNT_TO + 1);
    localparam logic [3:0] BL = 4'(BURST_LEN);

    state_t          state_q;
    logic [NREQ-1:0] gnt_q;
    logic [IW-1:0]   g_q;
    logic [IW-1:0]   ptr_q;
    logic [3:0]      cnt_q;
    logic [TW-1:0]   to_q;
    logic            err_q;

    logic [NREQ-1:0] pick_oh;
    logic [IW-1:0]   pick_idx;
    logic            pick_vld;
    logic            dsi_g;
    logic            req_g;
    logic [IW-1:0]   g_next;

    rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req_i    (REQ),
        .ptr_i    (ptr_q),
        .onehot_o (pick_oh),
        .idx_o    (pick_idx),
        .valid_o  (pick_vld)
    );

    assign dsi_g  = DSI_REQ[g_q];
    assign req_g  = REQ[g_q];
    assign g_next = (g_q == IW'(NREQ - 1)) ? '0 : g_q + 1'b1;

    always_comb begin
        M_DI = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (g_q == IW'(i)) M_DI = DI_REQ[i*WIDTH +: WIDTH];
        end
    end

    // The filter sees at most BURST_LEN strobes; anything past that is cut off here.
    always_comb begin
        M_DSI = 1'b0;
        case (state_q)
            GRANT:   M_DSI = dsi_g;
            LOAD:    M_DSI = dsi_g && (cnt_q < BL);
            default: M_DSI = 1'b0;
        endcase
    end

    assign DSO_REQ = (state_q == WAIT && M_DSO) ? gnt_q : '0;
    assign DO      = M_DO;
    assign BUSY    = (state_q != IDLE);
    assign GNT     = gnt_q;
    assign ERR     = err_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            g_q     <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            to_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= M_DSO && (state_q != WAIT);
            case (state_q)
                IDLE: begin
                    if (pick_vld) begin
                        gnt_q   <= pick_oh;
                        g_q     <= pick_idx;
                        to_q    <= '0;
                        state_q <= GRANT;
                    end
                end
                GRANT: begin
                    if (dsi_g) begin
                        cnt_q   <= 4'd1;
                        state_q <= LOAD;
                    end else if (!req_g || to_q == TW'(GNT_TO - 1)) begin
                        gnt_q   <= '0;
                        ptr_q   <= g_next;
                        state_q <= IDLE;
                    end else begin
                        to_q <= to_q + 1'b1;
                    end
                end
                LOAD: begin
                    if (dsi_g) begin
                        if (cnt_q == BL) begin
                            err_q   <= 1'b1;
                            state_q <= WAIT;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end else begin
                        // A short burst still goes to WAIT: the filter starts on DSI falling.
                        if (cnt_q != BL) err_q <= 1'b1;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (M_DSO) begin
                        gnt_q   <= '0;
                        ptr_q   <= g_next;
                        state_q <= GAP;
                    end
                end
                GAP:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_median_arbiter.sv
// Bench for median_arbiter with a behavioural median filter attached to the M_* ports.
module tb_median_arbiter;
  import median_pkg::*;

  localparam int NREQ   = 4;
  localparam int WIDTH  = 8;
  localparam int GNT_TO = 16;

  logic                  CLK = 1'b0;
  logic                  nRST = 1'b0;
  logic [NREQ-1:0]       REQ = '0;
  logic [NREQ-1:0]       GNT;
  logic [NREQ-1:0]       DSI_REQ = '0;
  logic [NREQ*WIDTH-1:0] DI_REQ = '0;
  logic [NREQ-1:0]       DSO_REQ;
  logic [WIDTH-1:0]      DO;
  logic                  M_DSI;
  logic [WIDTH-1:0]      M_DI;
  logic [WIDTH-1:0]      M_DO;
  logic                  M_DSO;
  logic                  BUSY;
  logic                  ERR;

  always #5 CLK = ~CLK;

  median_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .GNT_TO(GNT_TO)) dut (
    .CLK(CLK), .nRST(nRST), .REQ(REQ), .GNT(GNT), .DSI_REQ(DSI_REQ), .DI_REQ(DI_REQ),
    .DSO_REQ(DSO_REQ), .DO(DO), .M_DSI(M_DSI), .M_DI(M_DI), .M_DO(M_DO), .M_DSO(M_DSO),
    .BUSY(BUSY), .ERR(ERR)
  );

  function automatic logic [WIDTH-1:0] median_of(input logic [WIDTH-1:0] v[$]);
    logic [WIDTH-1:0] s[$];
    logic [WIDTH-1:0] t;
    s = v;
    if (s.size() == 0) return '0;
    for (int i = 0; i < s.size(); i++)
      for (int j = 0; j < s.size() - 1 - i; j++)
        if (s[j] > s[j+1]) begin
          t = s[j]; s[j] = s[j+1]; s[j+1] = t;
        end
    return s[s.size()/2];
  endfunction

  function automatic int exp_pick(input logic [NREQ-1:0] req, input int ptr);
    for (int k = 0; k < NREQ; k++)
      if (req[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    return -1;
  endfunction

  // Median filter model: collects strobed pixels, answers MED_LATENCY cycles after DSI falls.
  logic [WIDTH-1:0] mq[$];
  int               lat;
  logic             dsi_prev;

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      mq.delete();
      lat      <= 0;
      dsi_prev <= 1'b0;
      M_DSO    <= 1'b0;
      M_DO     <= '0;
    end else begin
      dsi_prev <= M_DSI;
      M_DSO    <= 1'b0;
      if (M_DSI) mq.push_back(M_DI);
      if (dsi_prev && !M_DSI) lat <= MED_LATENCY;
      else if (lat == 1) begin
        lat   <= 0;
        M_DSO <= 1'b1;
        M_DO  <= median_of(mq);
        mq.delete();
      end else if (lat > 1) lat <= lat - 1;
    end
  end

  // Event counters observed on the falling edge.
  int err_tot;
  int mdsi_tot;
  int dso_bad;
  int dso_tot [NREQ];

  always @(negedge CLK) begin
    if (nRST) begin
      if (ERR) err_tot <= err_tot + 1;
      if (M_DSI) mdsi_tot <= mdsi_tot + 1;
      for (int i = 0; i < NREQ; i++)
        if (DSO_REQ[i]) dso_tot[i] <= dso_tot[i] + 1;
      if ((DSO_REQ != '0 && DSO_REQ != GNT) || $countones(GNT) > 1) dso_bad <= dso_bad + 1;
    end
  end

  int               checks = 0;
  int               errors = 0;
  int               ptr_m = 0;
  logic [WIDTH-1:0] pix [11];

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_grant(output int gi);
    gi = -1;
    for (int n = 0; n < 60; n++) begin
      @(negedge CLK);
      if (GNT != '0) begin
        for (int i = 0; i < NREQ; i++) if (GNT[i]) gi = i;
        break;
      end
    end
  endtask

  task automatic drive_burst(input int r, input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge CLK); #1;
      DSI_REQ[r] = 1'b1;
      DI_REQ[r*WIDTH +: WIDTH] = pix[k];
    end
    @(posedge CLK); #1;
    DSI_REQ[r] = 1'b0;
  endtask

  task automatic wait_result(input int r, output int seen, output int dval);
    seen = 0;
    dval = -1;
    for (int n = 0; n < 120; n++) begin
      @(negedge CLK);
      if (DSO_REQ[r]) begin
        seen = 1;
        dval = int'(DO);
        break;
      end
    end
  endtask

  task automatic transaction(input int n, input bit drop, input string tag);
    int gi, seen, dval, e0, m0, d0, r, nk;
    logic [WIDTH-1:0] q[$];
    e0 = err_tot;
    m0 = mdsi_tot;
    r  = exp_pick(REQ, ptr_m);
    wait_grant(gi);
    check({tag, "_grant"}, gi, r);
    if (gi < 0) return;
    d0 = dso_tot[gi];
    drive_burst(gi, n);
    wait_result(gi, seen, dval);
    nk = (n < BURST_LEN) ? n : BURST_LEN;
    for (int k = 0; k < nk; k++) q.push_back(pix[k]);
    check({tag, "_dso_seen"}, seen, 1);
    check({tag, "_do"}, dval, int'(median_of(q)));
    @(posedge CLK); #1;
    if (drop) REQ = '0;
    @(posedge CLK); #1;
    check({tag, "_dso_count"}, dso_tot[gi] - d0, 1);
    check({tag, "_mdsi_cycles"}, mdsi_tot - m0, nk);
    check({tag, "_err_pulses"}, err_tot - e0, (n != BURST_LEN) ? 1 : 0);
    ptr_m = (r + 1) % NREQ;
  endtask

  task automatic do_reset();
    @(posedge CLK); #1;
    nRST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    nRST = 1'b1;
    ptr_m = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int single_px [9] = '{9, 1, 8, 2, 7, 3, 6, 4, 5};
    int gi, cnt, e0;

    // Reset values while reset is held.
    repeat (3) @(posedge CLK);
    #1;
    check("rst_gnt", int'(GNT), 0);
    check("rst_err", int'(ERR), 0);
    check("rst_busy", int'(BUSY), 0);
    check("rst_mdsi", int'(M_DSI), 0);
    check("rst_dso", int'(DSO_REQ), 0);
    nRST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;

    // Single burst on requester 0.
    for (int k = 0; k < 9; k++) pix[k] = WIDTH'(single_px[k]);
    REQ[0] = 1'b1;
    @(negedge CLK);
    check("single_gnt_before_edge", int'(GNT), 0);
    @(posedge CLK); #1;
    check("single_gnt_vec", int'(GNT), 1);
    transaction(9, 1'b1, "single");

    // Round-robin fairness with every requester asserted.
    do_reset();
    for (int k = 0; k < 9; k++) pix[k] = 8'h10;
    REQ = '1;
    for (int t = 0; t < 5; t++) transaction(9, t == 4, "rr");

    // Short burst: 8 strobes on requester 1.
    for (int k = 0; k < 9; k++) pix[k] = WIDTH'($urandom_range(0, 255));
    REQ[1] = 1'b1;
    transaction(8, 1'b1, "short");

    // Grant timeout on requester 2, then requester 3 is served with a long burst.
    @(posedge CLK); #1;
    e0 = err_tot;
    REQ = 4'b1100;
    wait_grant(gi);
    check("timeout_grant", gi, exp_pick(REQ, ptr_m));
    cnt = 1;
    for (int n = 0; n < 40; n++) begin
      @(negedge CLK);
      if (GNT[2]) cnt++;
      else break;
    end
    check("timeout_cycles", cnt, GNT_TO);
    @(posedge CLK); #1;
    REQ[2] = 1'b0;
    ptr_m = 3;
    check("timeout_err", err_tot - e0, 0);
    for (int k = 0; k < 11; k++) pix[k] = WIDTH'($urandom_range(0, 255));
    transaction(11, 1'b1, "long");

    // Reset while the filter is working, then a fresh burst.
    for (int k = 0; k < 9; k++) pix[k] = WIDTH'($urandom_range(0, 255));
    REQ[0] = 1'b1;
    wait_grant(gi);
    check("midrst_grant", gi, exp_pick(REQ, ptr_m));
    if (gi >= 0) drive_burst(gi, 9);
    repeat (10) @(negedge CLK);
    check("midrst_busy_before", int'(BUSY), 1);
    @(posedge CLK); #1;
    nRST = 1'b0;
    REQ  = '0;
    #1;
    check("midrst_gnt", int'(GNT), 0);
    check("midrst_busy", int'(BUSY), 0);
    check("midrst_dso", int'(DSO_REQ), 0);
    repeat (2) @(posedge CLK);
    #1;
    nRST = 1'b1;
    ptr_m = 0;
    for (int k = 0; k < 9; k++) pix[k] = WIDTH'($urandom_range(0, 255));
    REQ[1] = 1'b1;
    transaction(9, 1'b1, "post_rst");

    repeat (4) @(posedge CLK);
    #1;
    check("dso_routing", dso_bad, 0);
    check("idle_at_end", int'(BUSY), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
